// File: rtl/acc_step_decoder_if.sv
// acc_step_decoder_if: accumulator sum/enable observed by the decoder, and the recovered step outputs
interface acc_step_decoder_if #(
    parameter int W      = 11,
    parameter int WRAP_W = 8
);
    logic              enb;
    logic [W-1:0]      s;
    logic [W-1:0]      step;
    logic              step_vld;
    logic              locked;
    logic              err;
    logic [WRAP_W-1:0] wraps;
    modport master (output enb, s, input step, step_vld, locked, err, wraps);
    modport slave  (input enb, s, output step, step_vld, locked, err, wraps);
endinterface

// File: rtl/acc_step_decoder.sv
// acc_step_decoder: recovers the per-cycle increment of a modulo accumulator from its running sum,
// with lock detection, step-change error pulse and wrap counting
module acc_step_decoder #(
    parameter int W      = 11,
    parameter int LOCK_N = 4,
    parameter int WRAP_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    acc_step_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRIME, TRACK, LOCKED} state_t;
    localparam logic [3:0] LOCK_C = 4'(LOCK_N);
    state_t            state, state_nx;
    logic [W-1:0]      prev, prev_nx, step_q, step_nx, d;
    logic [3:0]        cnt, cnt_nx;
    logic [WRAP_W-1:0] wraps_q, wraps_nx;
    logic              err_q, err_nx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            prev    <= '0;
            step_q  <= '0;
            cnt     <= '0;
            wraps_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            prev    <= prev_nx;
            step_q  <= step_nx;
            cnt     <= cnt_nx;
            wraps_q <= wraps_nx;
            err_q   <= err_nx;
        end
    always_comb begin
        d        = bus.s - prev;
        state_nx = state;
        prev_nx  = prev;
        step_nx  = step_q;
        cnt_nx   = cnt;
        wraps_nx = wraps_q;
        err_nx   = 1'b0;
        if (!bus.enb) begin
            state_nx = IDLE;
            step_nx  = '0;
            cnt_nx   = '0;
        end else if (state == IDLE) begin
            prev_nx  = bus.s;
            wraps_nx = '0;
            state_nx = PRIME;
        end else begin
            prev_nx = bus.s;
            // s below prev can only happen when the sum rolled past 2^W
            if (bus.s < prev && wraps_q != '1)
                wraps_nx = wraps_q + WRAP_W'(1);
            if (state == PRIME) begin
                step_nx  = d;
                cnt_nx   = 4'd1;
                state_nx = TRACK;
            end else if (d != step_q) begin
                step_nx  = d;
                cnt_nx   = 4'd1;
                err_nx   = state == LOCKED;
                state_nx = TRACK;
            end else if (state == TRACK) begin
                cnt_nx   = cnt == 4'hf ? cnt : cnt + 4'd1;
                state_nx = cnt_nx == LOCK_C ? LOCKED : TRACK;
            end
        end
    end
    assign bus.step     = step_q;
    assign bus.step_vld = state == TRACK || state == LOCKED;
    assign bus.locked   = state == LOCKED;
    assign bus.err      = err_q;
    assign bus.wraps    = wraps_q;
endmodule
